// File: rtl/rv_sched_pkg.sv
// Purpose : shared types and helpers for the barrel-thread hart scheduler.
// Latency : n/a (types and constant functions only).
// Backpr. : n/a.
package rv_sched_pkg;

    localparam int MAX_HARTS  = 32;
    localparam int MAX_HART_W = 5;

    // Token carried down the pipeline chain. The id field is sized for the
    // largest supported hart count; narrower configurations use the low bits.
    typedef struct packed {
        logic                  valid;
        logic [MAX_HART_W-1:0] hart;
    } hart_tok_t;

    // $clog2 that never returns 0, so a hart id is at least one bit wide.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rv_rr_arbiter.sv
// Purpose : rotating-priority pick of one requester, scanning upward from ptr+1.
// Latency : purely combinational.
// Backpr. : none; grant is advisory, the caller decides whether to consume it.
// Ports   : req (request mask), ptr (last granted id) -> gnt_valid, gnt_id.
module rv_rr_arbiter
    import rv_sched_pkg::*;
#(
    parameter int NUM_HARTS = 8,
    parameter int HART_W    = clog2_min1(NUM_HARTS)
) (
    input  logic [NUM_HARTS-1:0] req,
    input  logic [HART_W-1:0]    ptr,
    output logic                 gnt_valid,
    output logic [HART_W-1:0]    gnt_id
);

    // Modulo indexing keeps ids below NUM_HARTS for non-power-of-two counts.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_id    = '0;
        for (int k = 1; k <= NUM_HARTS; k++) begin
            idx = (int'(ptr) + k) % NUM_HARTS;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = HART_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rv_hart_sched.sv
// Purpose : barrel-thread scheduler; issues one ready hart per enabled cycle into
//           a PIPE_DEPTH token chain with per-stage valid/hart taps.
// Latency : issue visible at stage 0 one edge after selection; retire PIPE_DEPTH-1 edges later.
// Backpr. : en=0 freezes the chain, busy mask and pointer; start/stop still apply.
// Ports   : clk, rst_n (sync, active low), en, hart_start/hart_stop pulses,
//           [hart_prio when RV_HART_PRIO_EN is defined], hart_active, hart_busy,
//           stage_valid, stage_hart, retire_valid, retire_hart, idle.
// Option  : RV_HART_PRIO_EN adds a two-level (priority, then normal) round robin.
module rv_hart_sched
    import rv_sched_pkg::*;
#(
    parameter int                   NUM_HARTS  = 8,
    parameter int                   HART_W     = clog2_min1(NUM_HARTS),
    parameter int                   PIPE_DEPTH = 7,
    parameter logic [NUM_HARTS-1:0] RESET_MASK = NUM_HARTS'(1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [NUM_HARTS-1:0]         hart_start,
    input  logic [NUM_HARTS-1:0]         hart_stop,
`ifdef RV_HART_PRIO_EN
    input  logic [NUM_HARTS-1:0]         hart_prio,
`endif
    output logic [NUM_HARTS-1:0]         hart_active,
    output logic [NUM_HARTS-1:0]         hart_busy,
    output logic [PIPE_DEPTH-1:0]        stage_valid,
    output logic [PIPE_DEPTH*HART_W-1:0] stage_hart,
    output logic                         retire_valid,
    output logic [HART_W-1:0]            retire_hart,
    output logic                         idle
);

    logic [NUM_HARTS-1:0] active, active_nxt;
    logic [NUM_HARTS-1:0] busy, busy_nxt;
    logic [NUM_HARTS-1:0] ready;
    logic [HART_W-1:0]    ptr, ptr_nxt;
    logic                 idle_q, idle_nxt;
    hart_tok_t            toks     [PIPE_DEPTH];
    hart_tok_t            toks_nxt [PIPE_DEPTH];

    logic                 sel_valid;
    logic [HART_W-1:0]    sel;
    logic                 lo_valid;
    logic [HART_W-1:0]    lo_id;

    assign retire_valid = toks[PIPE_DEPTH-1].valid;
    assign retire_hart  = toks[PIPE_DEPTH-1].hart[HART_W-1:0];

    // A retiring hart may be picked on the same edge its token leaves, which is
    // what lets PIPE_DEPTH harts fill every slot. A stop pulse masks the hart
    // immediately rather than waiting for the registered active bit.
    always_comb begin
        ready = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            ready[i] = active[i] & ~hart_stop[i] &
                       (~busy[i] | (retire_valid && (retire_hart == HART_W'(i))));
        end
    end

    rv_rr_arbiter #(
        .NUM_HARTS (NUM_HARTS),
        .HART_W    (HART_W)
    ) u_arb_lo (
        .req       (ready),
        .ptr       (ptr),
        .gnt_valid (lo_valid),
        .gnt_id    (lo_id)
    );

`ifdef RV_HART_PRIO_EN
    logic              hi_valid;
    logic [HART_W-1:0] hi_id;

    // Both levels share one pointer, so priority harts and normal harts each
    // rotate fairly relative to whoever issued last.
    rv_rr_arbiter #(
        .NUM_HARTS (NUM_HARTS),
        .HART_W    (HART_W)
    ) u_arb_hi (
        .req       (ready & hart_prio),
        .ptr       (ptr),
        .gnt_valid (hi_valid),
        .gnt_id    (hi_id)
    );

    assign sel_valid = hi_valid | lo_valid;
    assign sel       = hi_valid ? hi_id : lo_id;
`else
    assign sel_valid = lo_valid;
    assign sel       = lo_id;
`endif

    always_comb begin
        logic any_valid;
        // Stop beats start when both pulse together.
        active_nxt = (active | hart_start) & ~hart_stop;
        busy_nxt   = busy;
        ptr_nxt    = ptr;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            toks_nxt[k] = toks[k];
        end
        if (en) begin
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                toks_nxt[k] = toks[k-1];
            end
            toks_nxt[0].valid = sel_valid;
            toks_nxt[0].hart  = sel_valid ? MAX_HART_W'(sel) : '0;
            // Clear first so a same-hart reissue leaves busy set.
            if (retire_valid) begin
                busy_nxt[retire_hart] = 1'b0;
            end
            if (sel_valid) begin
                busy_nxt[sel] = 1'b1;
                ptr_nxt       = sel;
            end
        end
        any_valid = 1'b0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            any_valid = any_valid | toks_nxt[k].valid;
        end
        idle_nxt = ~any_valid & ~|active_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active <= RESET_MASK;
            busy   <= '0;
            ptr    <= HART_W'(NUM_HARTS - 1);
            idle_q <= ~|RESET_MASK;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                toks[k] <= '0;
            end
        end else begin
            active <= active_nxt;
            busy   <= busy_nxt;
            ptr    <= ptr_nxt;
            idle_q <= idle_nxt;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                toks[k] <= toks_nxt[k];
            end
        end
    end

    assign hart_active = active;
    assign hart_busy   = busy;
    assign idle        = idle_q;

    always_comb begin
        stage_valid = '0;
        stage_hart  = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            stage_valid[k]                = toks[k].valid;
            stage_hart[k*HART_W +: HART_W] = toks[k].hart[HART_W-1:0];
        end
    end

    // Token id bits above HART_W exist only for width padding.
    logic tok_pad_unused;
    always_comb begin
        tok_pad_unused = 1'b0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            tok_pad_unused = tok_pad_unused ^ (^toks[k].hart);
        end
    end

endmodule

// File: tb/tb_rv_hart_sched.sv
module tb_rv_hart_sched;

    localparam int NH = 8;
    localparam int HW = 3;
    localparam int PD = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [NH-1:0] hart_start;
    logic [NH-1:0] hart_stop;
    logic [NH-1:0] hart_prio;
    logic [NH-1:0] hart_active;
    logic [NH-1:0] hart_busy;
    logic [PD-1:0] stage_valid;
    logic [PD*HW-1:0] stage_hart;
    logic          retire_valid;
    logic [HW-1:0] retire_hart;
    logic          idle;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv_hart_sched #(
        .NUM_HARTS  (NH),
        .PIPE_DEPTH (PD),
        .RESET_MASK (8'h01)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .hart_start   (hart_start),
        .hart_stop    (hart_stop),
`ifdef RV_HART_PRIO_EN
        .hart_prio    (hart_prio),
`endif
        .hart_active  (hart_active),
        .hart_busy    (hart_busy),
        .stage_valid  (stage_valid),
        .stage_hart   (stage_hart),
        .retire_valid (retire_valid),
        .retire_hart  (retire_hart),
        .idle         (idle)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pack_ids(input int ids[PD]);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < PD; i++) v[i*HW +: HW] = ids[i][HW-1:0];
        return v;
    endfunction

    int seq2 [16];
    int seq3 [14] = '{6, 7, 0, 1, 2, 4, 5, 6, 7, 0, 1, 2, 4, 5};
    int seq6 [15] = '{4, 5, 6, 7, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 4};
    int stall_ids [PD] = '{5, 4, 2, 1, 0, 7, 6};
    int hist [$];

    initial begin
        rst_n = 1'b0; en = 1'b1; hart_start = '0; hart_stop = '0; hart_prio = '0;
        step(); step();

        // Reset state
        check_eq("rst_active", hart_active, 8'h01);
        check_eq("rst_busy",   hart_busy, 0);
        check_eq("rst_svalid", stage_valid, 0);
        check_eq("rst_shart",  stage_hart, 0);
        check_eq("rst_idle",   idle, 0);

        // 1: single hart, period PIPE_DEPTH
        rst_n = 1'b1;
        step();
        check_eq("t1_issue_v", stage_valid[0], 1);
        check_eq("t1_issue_h", stage_hart[HW-1:0], 0);
        check_eq("t1_busy",    hart_busy, 8'h01);
        for (int k = 1; k <= 6; k++) begin
            step();
            check_eq($sformatf("t1_bubble%0d", k), stage_valid[0], 0);
            check_eq($sformatf("t1_retv%0d", k), retire_valid, (k == 6) ? 1 : 0);
        end
        check_eq("t1_reth", retire_hart, 0);
        step();
        check_eq("t1_reissue_v", stage_valid[0], 1);
        check_eq("t1_reissue_h", stage_hart[HW-1:0], 0);

        // 2: start all harts, back-to-back issue with no repeats in window
        hart_start = 8'hFF;
        step();
        hart_start = '0;
        check_eq("t2_active", hart_active, 8'hFF);
        check_eq("t2_bubble", stage_valid[0], 0);
        for (int n = 0; n < 16; n++) seq2[n] = (n + 1) % NH;
        for (int n = 0; n < 16; n++) begin
            int dup;
            step();
            check_eq($sformatf("t2_v%0d", n), stage_valid[0], 1);
            check_eq($sformatf("t2_h%0d", n), stage_hart[HW-1:0], seq2[n]);
            dup = 0;
            foreach (hist[j]) if (hist[j] == int'(stage_hart[HW-1:0])) dup++;
            check_eq($sformatf("t2_win%0d", n), dup, 0);
            hist.push_back(int'(stage_hart[HW-1:0]));
            if (hist.size() > 6) void'(hist.pop_front());
        end

        // 3: stop hart 3 while its token is at stage 2
        for (int n = 0; n < 5; n++) step();
        check_eq("t3_at_s2", stage_hart[2*HW +: HW], 3);
        hart_stop = 8'h08;
        for (int j = 0; j < 14; j++) begin
            step();
            hart_stop = '0;
            if (j == 0) check_eq("t3_active", hart_active, 8'hF7);
            if (j == 3) begin
                check_eq("t3_retv", retire_valid, 1);
                check_eq("t3_reth", retire_hart, 3);
            end
            if (j == 4) check_eq("t3_busy3", hart_busy[3], 0);
            check_eq($sformatf("t3_v%0d", j), stage_valid[0], 1);
            check_eq($sformatf("t3_h%0d", j), stage_hart[HW-1:0], seq3[j]);
        end

        // 4: stall for 5 cycles
        en = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            check_eq($sformatf("t4_sv%0d", j), stage_valid, 7'h7F);
            check_eq($sformatf("t4_sh%0d", j), stage_hart, pack_ids(stall_ids));
            check_eq($sformatf("t4_busy%0d", j), hart_busy, 8'hF7);
            check_eq($sformatf("t4_retv%0d", j), retire_valid, 1);
            check_eq($sformatf("t4_reth%0d", j), retire_hart, 6);
        end
        en = 1'b1;
        step();
        check_eq("t4_resume_h", stage_hart[HW-1:0], 6);
        check_eq("t4_resume_ret", retire_hart, 7);
        check_eq("t4_resume_busy", hart_busy, 8'hF7);

        // 5: stop+start same cycle, then reset mid-stream
        hart_stop = 8'h04;
        step();
        hart_stop = 8'h04; hart_start = 8'h04;
        step();
        hart_stop = '0; hart_start = '0;
        check_eq("t5_stopwins", hart_active, 8'hF3);
        rst_n = 1'b0;
        step();
        check_eq("t5_rst_busy",   hart_busy, 0);
        check_eq("t5_rst_sv",     stage_valid, 0);
        check_eq("t5_rst_sh",     stage_hart, 0);
        check_eq("t5_rst_active", hart_active, 8'h01);
        check_eq("t5_rst_retv",   retire_valid, 0);
        rst_n = 1'b1;

        // start/stop still apply while frozen; idle once nothing is active
        en = 1'b0; hart_start = 8'h20;
        step();
        hart_start = '0;
        check_eq("t5_frz_active", hart_active, 8'h21);
        check_eq("t5_frz_sv", stage_valid, 0);
        check_eq("t5_frz_idle", idle, 0);
        hart_stop = 8'h21;
        step();
        hart_stop = '0;
        check_eq("t5_idle_active", hart_active, 0);
        check_eq("t5_idle", idle, 1);
        en = 1'b1;

`ifdef RV_HART_PRIO_EN
        // 6: hart 4 prioritised
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; hart_prio = 8'h10; hart_start = 8'hFF;
        step();
        hart_start = '0;
        check_eq("t6_first", stage_hart[HW-1:0], 0);
        for (int j = 0; j < 15; j++) begin
            step();
            check_eq($sformatf("t6_v%0d", j), stage_valid[0], 1);
            check_eq($sformatf("t6_h%0d", j), stage_hart[HW-1:0], seq6[j]);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
